// File: rtl/gcd_job_arbiter.sv
// rtl/gcd_job_arbiter.sv - round-robin job arbiter sequencing one shared GCD CPU
// Optional RUN-state watchdog enabled by defining GCD_ARB_TIMEOUT_EN.
module gcd_job_arbiter #(
  parameter int          NREQ         = 4,
  parameter int          RST_CYCLES   = 2,
  parameter int          START_CYCLES = 6,
  parameter logic [31:0] HALT_PC      = 32'h0000_0040,
  parameter int          TIMEOUT      = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_result,
  output logic                 rsp_error,
  output logic                 busy,
  output logic                 cpu_rst_n,
  output logic                 cpu_calc_start,
  output logic [31:0]          cpu_gcd_a,
  output logic [31:0]          cpu_gcd_b,
  input  logic [31:0]          cpu_gcd_result,
  input  logic [31:0]          cpu_pc
);

  localparam int PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAX_RS  = (RST_CYCLES > START_CYCLES) ? RST_CYCLES : START_CYCLES;
  localparam int MAX_ALL = (MAX_RS > TIMEOUT) ? MAX_RS : TIMEOUT;
  localparam int CW      = $clog2(MAX_ALL + 1);

  typedef enum logic [2:0] {IDLE, RSTCPU, START, RUN, DONE} state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] pick;
  logic [PW:0]   cand;
  logic          any_req;
  logic [CW-1:0] cnt;

`ifdef GCD_ARB_TIMEOUT_EN
  logic err_q;
  assign rsp_error = err_q;
`else
  assign rsp_error = 1'b0;
`endif

  // Descending scan so the candidate closest to rr_ptr is the last one to win.
  always_comb begin
    pick      = rr_ptr;
    any_req   = 1'b0;
    cand      = '0;
    req_ready = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
      if (req_valid[cand[PW-1:0]]) begin
        pick    = cand[PW-1:0];
        any_req = 1'b1;
      end
    end
    if (state == IDLE && any_req) req_ready[pick] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      grant_idx      <= '0;
      cnt            <= '0;
      rsp_valid      <= '0;
      rsp_result     <= '0;
      busy           <= 1'b0;
      cpu_rst_n      <= 1'b0;
      cpu_calc_start <= 1'b0;
      cpu_gcd_a      <= '0;
      cpu_gcd_b      <= '0;
`ifdef GCD_ARB_TIMEOUT_EN
      err_q          <= 1'b0;
`endif
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_idx <= pick;
            cpu_gcd_a <= req_a[32*int'(pick) +: 32];
            cpu_gcd_b <= req_b[32*int'(pick) +: 32];
            cnt       <= CW'(RST_CYCLES - 1);
            busy      <= 1'b1;
            state     <= RSTCPU;
          end
        end
        RSTCPU: begin
          if (cnt == '0) begin
            cnt            <= CW'(START_CYCLES - 1);
            cpu_rst_n      <= 1'b1;
            cpu_calc_start <= 1'b1;
            state          <= START;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        START: begin
          if (cnt == '0) begin
            cnt            <= CW'(TIMEOUT - 1);
            cpu_calc_start <= 1'b0;
            state          <= RUN;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RUN: begin
          // The halt address is only trusted once the CPU is free-running.
          if (cpu_pc == HALT_PC) begin
            rsp_result           <= cpu_gcd_result;
            rsp_valid[grant_idx] <= 1'b1;
            cpu_rst_n            <= 1'b0;
            state                <= DONE;
`ifdef GCD_ARB_TIMEOUT_EN
            err_q                <= 1'b0;
          end else if (cnt == '0) begin
            rsp_result           <= '0;
            rsp_valid[grant_idx] <= 1'b1;
            cpu_rst_n            <= 1'b0;
            err_q                <= 1'b1;
            state                <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
`endif
          end
        end
        DONE: begin
          rr_ptr <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
          busy   <= 1'b0;
          state  <= IDLE;
`ifdef GCD_ARB_TIMEOUT_EN
          err_q  <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_job_arbiter.sv
// tb/tb_gcd_job_arbiter.sv - scoreboard bench for gcd_job_arbiter with a behavioural CPU stand-in
`timescale 1ns/1ps
module tb_gcd_job_arbiter;

  localparam int          NREQ = 4;
  localparam int          RSTC = 2;
  localparam int          STC  = 6;
  localparam int          TMO  = 64;
  localparam logic [31:0] HALT = 32'h0000_0040;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_a, req_b;
  logic [NREQ-1:0]    req_ready, rsp_valid;
  logic [31:0]        rsp_result;
  logic               rsp_error, busy, cpu_rst_n, cpu_calc_start;
  logic [31:0]        cpu_gcd_a, cpu_gcd_b, cpu_gcd_result, cpu_pc;

  typedef struct {
    int          idx;
    logic [31:0] res;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   xfer_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  gcd_job_arbiter #(
    .NREQ(NREQ), .RST_CYCLES(RSTC), .START_CYCLES(STC), .HALT_PC(HALT), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .rsp_error(rsp_error), .busy(busy), .cpu_rst_n(cpu_rst_n),
    .cpu_calc_start(cpu_calc_start), .cpu_gcd_a(cpu_gcd_a), .cpu_gcd_b(cpu_gcd_b),
    .cpu_gcd_result(cpu_gcd_result), .cpu_pc(cpu_pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // CPU stand-in: subtractive GCD, halts rl cycles after calc_start drops.
  logic [31:0] m_pc, m_a, m_b;
  int          m_cnt;
  logic        m_started;
  int          rl    = 0;
  bit          hang  = 1'b0;
  bit          early = 1'b0;

  function automatic logic [31:0] sub_gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x = a, y = b;
    if (x == 0) return y;
    if (y == 0) return x;
    while (x != y) begin
      if (x > y) x = x - y; else y = y - x;
    end
    return x;
  endfunction

  always @(posedge clk) begin
    if (!cpu_rst_n) begin
      m_pc <= 32'h0; m_cnt <= 0; m_started <= 1'b0; cpu_gcd_result <= 32'h0;
    end else if (cpu_calc_start) begin
      m_started <= 1'b1; m_a <= cpu_gcd_a; m_b <= cpu_gcd_b; m_pc <= 32'h4;
    end else if (m_started) begin
      m_cnt <= m_cnt + 1;
      if (!hang && m_cnt >= rl) begin
        m_pc <= HALT; cpu_gcd_result <= sub_gcd(m_a, m_b);
      end else begin
        m_pc <= 32'h8;
      end
    end
  end

  assign cpu_pc = (early && cpu_calc_start) ? HALT : m_pc;

  task automatic push_exp(input int i, input logic [31:0] r, input logic er, input int l);
    exp_t e;
    e.idx = i; e.res = r; e.err = er; e.lat = l;
    exp_q.push_back(e);
  endtask

  task automatic put(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_valid[i]      = 1'b1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_n = 1'b0;
    hang = 1'b0; early = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete(); xfer_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk); #1; n++;
    end
    ok = (exp_q.size() == 0);
  endtask

  task automatic monitor();
    exp_t            e;
    int              t;
    logic [NREQ-1:0] ev;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (|(req_valid & req_ready)) xfer_q.push_back(cyc);
        if (|rsp_valid) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_rsp: rsp_valid=%b result=%0d, required no response", rsp_valid, rsp_result);
          end else begin
            e = exp_q.pop_front();
            t = -1000;
            if (xfer_q.size() > 0) t = xfer_q.pop_front();
            ev = '0; ev[e.idx] = 1'b1;
            total++;
            if (rsp_valid !== ev) begin
              bad++; $display("FAIL rsp_valid: got %b required %b", rsp_valid, ev);
            end
            total++;
            if (rsp_result !== e.res) begin
              bad++; $display("FAIL rsp_result: got %0d required %0d", rsp_result, e.res);
            end
            total++;
            if (rsp_error !== e.err) begin
              bad++; $display("FAIL rsp_error: got %b required %b", rsp_error, e.err);
            end
            total++;
            if (cyc - t !== e.lat) begin
              bad++; $display("FAIL rsp_latency: got %0d required %0d", cyc - t, e.lat);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({busy, cpu_rst_n, cpu_calc_start, rsp_error} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl: busy/rst/start/err=%b required 0000", {busy, cpu_rst_n, cpu_calc_start, rsp_error});
    end
    total++;
    if (rsp_valid !== '0 || rsp_result !== '0) begin
      bad++; $display("FAIL reset_rsp: valid=%b result=%0d required 0/0", rsp_valid, rsp_result);
    end
    total++;
    if (cpu_gcd_a !== '0 || cpu_gcd_b !== '0) begin
      bad++; $display("FAIL reset_ops: a=%0d b=%0d required 0/0", cpu_gcd_a, cpu_gcd_b);
    end
    total++;
    if (req_ready !== '0) begin
      bad++; $display("FAIL reset_ready_idle: got %b required 0000", req_ready);
    end
    req_valid = 4'b1010; #1;
    total++;
    if (req_ready !== 4'b0010) begin
      bad++; $display("FAIL reset_ready_pick: got %b required 0010", req_ready);
    end
    req_valid = 4'b0100; #1;
    total++;
    if (req_ready !== 4'b0100) begin
      bad++; $display("FAIL reset_ready_pick2: got %b required 0100", req_ready);
    end
    req_valid = '0;
  endtask

  task automatic test_single();
    int n;
    bit ok;
    do_reset(); rl = 2;
    @(posedge clk); #1;
    put(0, 15, 10);
    push_exp(0, 32'd5, 1'b0, RSTC + STC + 3 + 2);
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0001) begin
      bad++; $display("FAIL single_ready: got %b required 0001", req_ready);
    end
    @(posedge clk); #1; req_valid = '0;
    n = 0; @(negedge clk);
    while (!cpu_rst_n && n < 50) begin n++; @(negedge clk); end
    total++;
    if (n !== RSTC) begin
      bad++; $display("FAIL single_rst_cycles: got %0d required %0d", n, RSTC);
    end
    n = 0;
    while (cpu_calc_start && n < 50) begin n++; @(negedge clk); end
    total++;
    if (n !== STC) begin
      bad++; $display("FAIL single_start_cycles: got %0d required %0d", n, STC);
    end
    total++;
    if (cpu_gcd_a !== 32'd15 || cpu_gcd_b !== 32'd10) begin
      bad++; $display("FAIL single_operands: a=%0d b=%0d required 15/10", cpu_gcd_a, cpu_gcd_b);
    end
    wait_drain(100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_timeout: response missing, required 1"); end
  endtask

  task automatic test_simultaneous();
    int n;
    bit ok;
    do_reset(); rl = 0;
    @(posedge clk); #1;
    put(0, 15, 10); put(2, 21, 14);
    push_exp(0, 32'd5, 1'b0, RSTC + STC + 3);
    push_exp(2, 32'd7, 1'b0, RSTC + STC + 3);
    @(negedge clk);
    total++;
    if (req_ready !== 4'b0001) begin
      bad++; $display("FAIL sim_first_grant: got %b required 0001", req_ready);
    end
    @(posedge clk); #1; req_valid[0] = 1'b0;
    n = 0; @(negedge clk);
    while (rsp_valid[0] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    total++;
    if (n >= 100) begin bad++; $display("FAIL sim_first_rsp: not seen, required within 100"); end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || req_ready !== 4'b0100) begin
      bad++; $display("FAIL sim_gap: busy=%b ready=%b required 0/0100", busy, req_ready);
    end
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL sim_busy_again: got %b required 1", busy); end
    wait_drain(100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL sim_timeout: responses missing, required 0 left"); end
  endtask

  task automatic test_fairness();
    int fr[4] = '{4, 3, 5, 7};
    bit ok;
    do_reset(); rl = 1;
    @(posedge clk); #1;
    put(0, 12, 8); put(1, 9, 6); put(2, 35, 25); put(3, 14, 21);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) push_exp(i, fr[i], 1'b0, RSTC + STC + 4);
    wait_drain(400, ok);
    @(posedge clk); #1; req_valid = '0;
    total++;
    if (!ok) begin bad++; $display("FAIL fair_timeout: %0d responses left, required 0", exp_q.size()); end
  endtask

  task automatic test_early_halt();
    bit ok;
    do_reset(); early = 1'b1; rl = 3;
    @(posedge clk); #1;
    put(1, 27, 18);
    push_exp(1, 32'd9, 1'b0, RSTC + STC + 3 + 3);
    @(posedge clk); #1; req_valid = '0;
    wait_drain(100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL early_timeout: response missing, required 1"); end
    early = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int n;
    bit ok;
    do_reset(); hang = 1'b1; rl = 0;
    @(posedge clk); #1; put(3, 100, 75);
    @(posedge clk); #1; req_valid = '0;
    n = 0;
    while (!(busy && cpu_rst_n && !cpu_calc_start) && n < 100) begin @(negedge clk); n++; end
    total++;
    if (n >= 100) begin bad++; $display("FAIL mid_run_entry: RUN not reached, required within 100"); end
    repeat (3) @(negedge clk);
    #1; rst_n = 1'b0; #1;
    total++;
    if ({busy, cpu_rst_n, cpu_calc_start, rsp_error} !== 4'b0000 || rsp_valid !== '0) begin
      bad++; $display("FAIL mid_run_ctrl: busy/rst/start/err=%b valid=%b required 0000/0000",
                      {busy, cpu_rst_n, cpu_calc_start, rsp_error}, rsp_valid);
    end
    total++;
    if (cpu_gcd_a !== '0 || cpu_gcd_b !== '0 || rsp_result !== '0) begin
      bad++; $display("FAIL mid_run_data: a=%0d b=%0d res=%0d required 0/0/0", cpu_gcd_a, cpu_gcd_b, rsp_result);
    end
    xfer_q.delete();
    @(posedge clk); #1; rst_n = 1'b1; hang = 1'b0;
    repeat (20) @(negedge clk);
    @(posedge clk); #1; put(1, 48, 18);
    push_exp(1, 32'd6, 1'b0, RSTC + STC + 3);
    @(posedge clk); #1; req_valid = '0;
    wait_drain(100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL mid_run_new_job: response missing, required 1"); end
  endtask

`ifdef GCD_ARB_TIMEOUT_EN
  task automatic test_watchdog();
    bit ok;
    do_reset(); hang = 1'b1;
    @(posedge clk); #1; put(2, 8, 4);
    push_exp(2, 32'd0, 1'b1, RSTC + STC + 1 + TMO);
    @(posedge clk); #1; req_valid = '0;
    wait_drain(300, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL watchdog_timeout: abort response missing, required 1"); end
    hang = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_early_halt();
    test_reset_mid_run();
`ifdef GCD_ARB_TIMEOUT_EN
    test_watchdog();
`endif
    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
